fft_mag_peak: RTL and testbench
===============================

Name: fft_mag_peak

Overview:
Streaming post-processor between the FFT controller output (re/im/valid/index) and the FIFO controller input. It computes the full-precision squared magnitude of every FFT bin in a fixed 3-cycle pipeline and forwards it with its bin index. It also tracks the peak bin over the positive-frequency half of each frame, and reports peak magnitude and index once per complete frame. Frames with a broken index sequence are detected and discarded.

Parameters:
IN_W, 32, signed width of data_re / data_im
IDX_W, 16, width of bin index (matches FFT tuser)
NFFT, 1024, transform length; legal index range 0..NFFT-1
SKIP_DC, 1, 1 = bin 0 excluded from peak search
MAG_W, 2*IN_W+1, derived localparam; squared-magnitude width

Ports:
clk  in  1  system clock (100 MHz domain)
rst  in  1  asynchronous reset, active-high
data_re  in  IN_W  signed real part from FFT
data_im  in  IN_W  signed imaginary part from FFT
data_valid  in  1  input sample valid, no back-pressure
data_index  in  IDX_W  bin index of the input sample
mag_out  out  MAG_W  re^2+im^2, unsigned
mag_valid  out  1  mag_out/mag_index valid
mag_index  out  IDX_W  bin index of mag_out
peak_mag  out  MAG_W  largest magnitude of last good frame
peak_index  out  IDX_W  bin of peak_mag
peak_valid  out  1  one-cycle pulse, new peak result available
seq_err  out  1  one-cycle pulse on index discontinuity

Behaviour:
- Reset (async assert, sync release): all outputs 0; expected index 0; tracker state IDLE; pipeline valids cleared.
- Pipeline: S1 registers re/im/index/valid. S2 registers re*re and im*im (signed x signed, 2*IN_W bits, non-negative). S3 registers the sum, zero-extended to MAG_W. Latency is exactly 3 cycles from data_valid to mag_valid. Throughput is 1 sample per cycle. Gaps in data_valid propagate unchanged. No saturation: MAG_W holds the worst case (-2^(IN_W-1))^2*2.
- mag_out is forwarded for every valid sample, including samples in discarded frames. The downstream FIFO decides what to store.
- Tracker FSM, evaluated on S3 output:
  - IDLE: wait for valid with index 0. On that sample, go to RUN, set expected=1, and load the candidate peak (0 if SKIP_DC, else the bin-0 magnitude, index 0).
  - RUN: on each valid sample:
    - If index != expected: pulse seq_err and go to IDLE. If that same sample has index 0, it immediately restarts the frame (RUN, expected=1).
    - Otherwise expected++. If index < NFFT/2 and mag > candidate (strict), update the candidate. Ties keep the lower index.
    - If index == NFFT-1: peak_mag/peak_index <= candidate, pulse peak_valid next cycle, go to IDLE.
- peak_mag/peak_index hold until the next good frame ends.
- Index 0 arriving in RUN with expected != 0 counts as a discontinuity, handled per the rule above.
- An index >= NFFT is treated as a discontinuity.
- Reset mid-frame discards the partial frame. No peak_valid is issued for it.
- All-zero frame with SKIP_DC=1: peak_mag=0, peak_index=0.

Decomposition:
- Package fft_mag_pkg holds:
  - MAG_W derivation function
  - tracker state enum (IDLE, RUN)
  - NFFT/2 constant helper
- One sub-module, mag_sq_pipe: the 3-stage re^2+im^2 pipeline with valid/index sideband. fft_mag_peak instantiates it and adds the tracker FSM.

Test Plan:
- Single sample re=3, im=-4, index=0, valid for 1 cycle -> mag_valid high exactly 3 cycles later with mag_out=25, mag_index=0.
- Frame NFFT=16 (bench override), indices 0..15 contiguous, bin 5 = (100,0), bin 12 = (200,0), others 0 -> peak_valid pulse 4 cycles after index 15 input, peak_mag=10000, peak_index=5 (bin 12 is above NFFT/2).
- Same frame but bins 3 and 6 both (7,7) -> peak_mag=98, peak_index=3 (tie keeps first). With SKIP_DC=1 and bin 0=(1000,0) -> bin 0 ignored.
- Indices 0,1,2,4 -> seq_err pulse on the index-4 sample, no peak_valid for that frame. A following clean 0..15 frame yields a normal peak_valid.
- Extreme values re=im=-2^31 -> mag_out=2^63 exactly, no wrap.
- rst asserted at index 8 of a frame -> all outputs 0 immediately (asynchronous). After release, a full frame produces peak_valid; the partial frame produces nothing.

Source files
------------

// File: rtl/fft_mag_pkg.sv
// Shared definitions for the FFT magnitude / peak post-processor.
//   mag_width : squared-magnitude width for a given signed input width
//   half_len  : number of non-negative-frequency bins searched for the peak
//   trk_state_t : frame tracker states
package fft_mag_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } trk_state_t;

   // re^2 + im^2 needs 2*IN_W bits per square plus one carry bit:
   // (-2^(IN_W-1))^2 * 2 = 2^(2*IN_W-1) exactly.
   function automatic int mag_width(input int in_w);
      return 2 * in_w + 1;
   endfunction

   function automatic int half_len(input int nfft);
      return nfft / 2;
   endfunction

endpackage

// File: rtl/fft_mag_peak_mag_sq_pipe.sv
// mag_sq_pipe: fixed 3-stage squared-magnitude pipeline with valid/index
// sideband.  One sample per cycle, no back-pressure, gaps pass through.
//   clk, rst          : clock, asynchronous active-high reset
//   data_re, data_im  : signed input sample
//   data_valid        : input sample valid
//   data_index        : bin index of the input sample
//   mag_out           : re^2 + im^2, unsigned, 3 cycles after input
//   mag_valid         : mag_out / mag_index valid
//   mag_index         : bin index of mag_out
module mag_sq_pipe
   import fft_mag_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int IDX_W = 16,
   localparam int MAG_W = mag_width(IN_W)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  data_re,
   input  logic signed [IN_W-1:0]  data_im,
   input  logic                    data_valid,
   input  logic [IDX_W-1:0]        data_index,
   output logic [MAG_W-1:0]        mag_out,
   output logic                    mag_valid,
   output logic [IDX_W-1:0]        mag_index
);

   localparam int PROD_W = 2 * IN_W;

   logic signed [IN_W-1:0]   s1_re;
   logic signed [IN_W-1:0]   s1_im;
   logic [IDX_W-1:0]         s1_idx;
   logic                     s1_vld;

   logic [PROD_W-1:0]        s2_sq_re;
   logic [PROD_W-1:0]        s2_sq_im;
   logic [IDX_W-1:0]         s2_idx;
   logic                     s2_vld;

   logic signed [PROD_W-1:0] re_ext;
   logic signed [PROD_W-1:0] im_ext;
   logic signed [PROD_W-1:0] prod_re;
   logic signed [PROD_W-1:0] prod_im;

   // Operands are sign-extended to the product width so the multiply is a
   // full-precision signed square; the result is always non-negative.
   assign re_ext  = {{IN_W{s1_re[IN_W-1]}}, s1_re};
   assign im_ext  = {{IN_W{s1_im[IN_W-1]}}, s1_im};
   assign prod_re = re_ext * re_ext;
   assign prod_im = im_ext * im_ext;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_re     <= '0;
         s1_im     <= '0;
         s1_idx    <= '0;
         s1_vld    <= 1'b0;
         s2_sq_re  <= '0;
         s2_sq_im  <= '0;
         s2_idx    <= '0;
         s2_vld    <= 1'b0;
         mag_out   <= '0;
         mag_index <= '0;
         mag_valid <= 1'b0;
      end else begin
         s1_re     <= data_re;
         s1_im     <= data_im;
         s1_idx    <= data_index;
         s1_vld    <= data_valid;

         s2_sq_re  <= prod_re;
         s2_sq_im  <= prod_im;
         s2_idx    <= s1_idx;
         s2_vld    <= s1_vld;

         mag_out   <= {1'b0, s2_sq_re} + {1'b0, s2_sq_im};
         mag_index <= s2_idx;
         mag_valid <= s2_vld;
      end
   end

endmodule

// File: rtl/fft_mag_peak.sv
// fft_mag_peak: streaming squared-magnitude and per-frame peak finder
// between the FFT output and the FIFO controller.
//   clk, rst            : clock, asynchronous active-high reset
//   data_re/im/valid/index : FFT output stream (no back-pressure)
//   mag_out/valid/index : squared magnitude of every valid bin, 3-cycle latency
//   peak_mag/index      : peak of the last complete, contiguous frame
//   peak_valid          : one-cycle pulse when a new peak result is loaded
//   seq_err             : one-cycle pulse on an index discontinuity
//
// Tracker FSM (runs on the pipeline output)
//   state | meaning
//   IDLE  | waiting for a valid bin 0 to start a frame
//   RUN   | inside a frame, expecting bin exp_idx next
module fft_mag_peak
   import fft_mag_pkg::*;
#(
   parameter int IN_W    = 32,
   parameter int IDX_W   = 16,
   parameter int NFFT    = 1024,
   parameter int SKIP_DC = 1,
   localparam int MAG_W  = mag_width(IN_W)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  data_re,
   input  logic signed [IN_W-1:0]  data_im,
   input  logic                    data_valid,
   input  logic [IDX_W-1:0]        data_index,
   output logic [MAG_W-1:0]        mag_out,
   output logic                    mag_valid,
   output logic [IDX_W-1:0]        mag_index,
   output logic [MAG_W-1:0]        peak_mag,
   output logic [IDX_W-1:0]        peak_index,
   output logic                    peak_valid,
   output logic                    seq_err
);

   localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(half_len(NFFT));
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFFT - 1);

   mag_sq_pipe #(
      .IN_W  (IN_W),
      .IDX_W (IDX_W)
   ) u_pipe (
      .clk        (clk),
      .rst        (rst),
      .data_re    (data_re),
      .data_im    (data_im),
      .data_valid (data_valid),
      .data_index (data_index),
      .mag_out    (mag_out),
      .mag_valid  (mag_valid),
      .mag_index  (mag_index)
   );

   trk_state_t        state, state_n;
   logic [IDX_W-1:0]  exp_idx, exp_idx_n;
   logic [MAG_W-1:0]  cand_mag, cand_mag_n;
   logic [IDX_W-1:0]  cand_idx, cand_idx_n;
   logic              peak_load;
   logic              seq_err_n;
   logic              frame_start;

   // The candidate starts at 0 when DC is excluded, so an all-zero frame
   // reports magnitude 0 at bin 0.
   always_comb begin
      state_n     = state;
      exp_idx_n   = exp_idx;
      cand_mag_n  = cand_mag;
      cand_idx_n  = cand_idx;
      peak_load   = 1'b0;
      seq_err_n   = 1'b0;
      frame_start = 1'b0;

      case (state)
         IDLE: begin
            if (mag_valid && (mag_index == '0)) begin
               frame_start = 1'b1;
            end
         end
         RUN: begin
            if (mag_valid) begin
               // exp_idx never exceeds NFFT-1 in RUN, so an out-of-range
               // index always lands here as a discontinuity.
               if (mag_index != exp_idx) begin
                  seq_err_n = 1'b1;
                  state_n   = IDLE;
                  if (mag_index == '0) begin
                     frame_start = 1'b1;
                  end
               end else begin
                  exp_idx_n = exp_idx + IDX_W'(1);
                  if ((mag_index < HALF_IDX) && (mag_out > cand_mag)) begin
                     cand_mag_n = mag_out;
                     cand_idx_n = mag_index;
                  end
                  if (mag_index == LAST_IDX) begin
                     peak_load = 1'b1;
                     state_n   = IDLE;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase

      if (frame_start) begin
         state_n    = RUN;
         exp_idx_n  = IDX_W'(1);
         cand_idx_n = '0;
         cand_mag_n = (SKIP_DC != 0) ? '0 : mag_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         exp_idx    <= '0;
         cand_mag   <= '0;
         cand_idx   <= '0;
         peak_mag   <= '0;
         peak_index <= '0;
         peak_valid <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         state      <= state_n;
         exp_idx    <= exp_idx_n;
         cand_mag   <= cand_mag_n;
         cand_idx   <= cand_idx_n;
         peak_valid <= peak_load;
         seq_err    <= seq_err_n;
         if (peak_load) begin
            peak_mag   <= cand_mag_n;
            peak_index <= cand_idx_n;
         end
      end
   end

endmodule

// File: tb/tb_fft_mag_peak.sv
module tb_fft_mag_peak;
   import fft_mag_pkg::*;

   localparam int IN_W  = 32;
   localparam int IDX_W = 16;
   localparam int NFFT  = 16;
   localparam int SKIP  = 1;
   localparam int MW    = 2 * IN_W + 1;

   logic                   clk;
   logic                   rst;
   logic signed [IN_W-1:0] data_re;
   logic signed [IN_W-1:0] data_im;
   logic                   data_valid;
   logic [IDX_W-1:0]       data_index;
   logic [MW-1:0]          mag_out;
   logic                   mag_valid;
   logic [IDX_W-1:0]       mag_index;
   logic [MW-1:0]          peak_mag;
   logic [IDX_W-1:0]       peak_index;
   logic                   peak_valid;
   logic                   seq_err;

   fft_mag_peak #(
      .IN_W    (IN_W),
      .IDX_W   (IDX_W),
      .NFFT    (NFFT),
      .SKIP_DC (SKIP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_re    (data_re),
      .data_im    (data_im),
      .data_valid (data_valid),
      .data_index (data_index),
      .mag_out    (mag_out),
      .mag_valid  (mag_valid),
      .mag_index  (mag_index),
      .peak_mag   (peak_mag),
      .peak_index (peak_index),
      .peak_valid (peak_valid),
      .seq_err    (seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int step_no = 0;

   // Reference model: expected events keyed by the step in which they appear.
   bit            exp_mv [int];
   logic [MW-1:0] exp_mag [int];
   logic [15:0]   exp_mi [int];
   bit            exp_pv [int];
   logic [MW-1:0] exp_pk_mag [int];
   logic [15:0]   exp_pk_idx [int];
   bit            exp_se [int];

   bit            in_frame = 1'b0;
   int            cnt = 0;
   logic [MW-1:0] frame_mag [NFFT];
   logic [MW-1:0] cur_pk_mag = '0;
   logic [15:0]   cur_pk_idx = '0;

   logic signed [IN_W-1:0] fr_re [NFFT];
   logic signed [IN_W-1:0] fr_im [NFFT];

   task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [MW-1:0] ref_mag(input logic signed [IN_W-1:0] re,
                                             input logic signed [IN_W-1:0] im);
      longint a, b;
      a = re;
      b = im;
      return MW'(a * a) + MW'(b * b);
   endfunction

   task automatic model_sample(input logic signed [IN_W-1:0] re,
                               input logic signed [IN_W-1:0] im,
                               input logic [15:0] idx);
      logic [MW-1:0] m, best;
      int bi;
      m = ref_mag(re, im);
      exp_mv[step_no + 3]  = 1'b1;
      exp_mag[step_no + 3] = m;
      exp_mi[step_no + 3]  = idx;
      if (in_frame && int'(idx) != cnt) begin
         exp_se[step_no + 4] = 1'b1;
         in_frame = 1'b0;
      end
      if (!in_frame && idx == 16'd0) begin
         in_frame = 1'b1;
         cnt = 0;
      end
      if (in_frame) begin
         frame_mag[cnt] = m;
         cnt++;
         if (cnt == NFFT) begin
            best = '0;
            bi = 0;
            for (int i = (SKIP != 0) ? 1 : 0; i < NFFT / 2; i++) begin
               if (frame_mag[i] > best) begin
                  best = frame_mag[i];
                  bi = i;
               end
            end
            exp_pv[step_no + 4]     = 1'b1;
            exp_pk_mag[step_no + 4] = best;
            exp_pk_idx[step_no + 4] = 16'(bi);
            in_frame = 1'b0;
         end
      end
   endtask

   task automatic check_outputs();
      int j;
      j = step_no;
      chk("mag_valid", MW'(mag_valid), MW'(exp_mv.exists(j)));
      if (exp_mv.exists(j)) begin
         chk("mag_out", mag_out, exp_mag[j]);
         chk("mag_index", MW'(mag_index), MW'(exp_mi[j]));
      end
      chk("peak_valid", MW'(peak_valid), MW'(exp_pv.exists(j)));
      if (exp_pv.exists(j)) begin
         cur_pk_mag = exp_pk_mag[j];
         cur_pk_idx = exp_pk_idx[j];
      end
      chk("peak_mag", peak_mag, cur_pk_mag);
      chk("peak_index", MW'(peak_index), MW'(cur_pk_idx));
      chk("seq_err", MW'(seq_err), MW'(exp_se.exists(j)));
   endtask

   task automatic step(input bit v, input logic signed [IN_W-1:0] re,
                       input logic signed [IN_W-1:0] im, input logic [15:0] idx);
      data_valid = v;
      data_re    = re;
      data_im    = im;
      data_index = idx;
      if (v) model_sample(re, im, idx);
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      #1;
      step_no++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
   endtask

   task automatic clear_frame();
      for (int i = 0; i < NFFT; i++) begin
         fr_re[i] = '0;
         fr_im[i] = '0;
      end
   endtask

   task automatic send_frame(input bit gaps);
      for (int i = 0; i < NFFT; i++) begin
         while (gaps && $urandom_range(0, 3) == 0) idle(1);
         step(1'b1, fr_re[i], fr_im[i], 16'(i));
      end
   endtask

   task automatic do_reset();
      data_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_mag_out", mag_out, '0);
      chk("rst_mag_valid", MW'(mag_valid), '0);
      chk("rst_mag_index", MW'(mag_index), '0);
      chk("rst_peak_mag", peak_mag, '0);
      chk("rst_peak_index", MW'(peak_index), '0);
      chk("rst_peak_valid", MW'(peak_valid), '0);
      chk("rst_seq_err", MW'(seq_err), '0);
      exp_mv.delete();
      exp_mag.delete();
      exp_mi.delete();
      exp_pv.delete();
      exp_pk_mag.delete();
      exp_pk_idx.delete();
      exp_se.delete();
      in_frame = 1'b0;
      cur_pk_mag = '0;
      cur_pk_idx = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      step_no += 4;
   endtask

   task automatic random_frame(input int mode);
      int p;
      logic [15:0] idx;
      p = $urandom_range(1, NFFT - 1);
      for (int i = 0; i < NFFT; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            fr_re[i] = $signed($urandom);
            fr_im[i] = $signed($urandom);
         end else begin
            fr_re[i] = $signed(32'($urandom_range(0, 6))) - 32'sd3;
            fr_im[i] = $signed(32'($urandom_range(0, 6))) - 32'sd3;
         end
      end
      for (int i = 0; i < NFFT; i++) begin
         while ($urandom_range(0, 3) == 0) idle(1);
         idx = 16'(i);
         if (mode == 1 && i == p) idx = 16'(p + 1);
         if (mode == 2 && i == p) idx = 16'(NFFT + $urandom_range(0, 100));
         step(1'b1, fr_re[i], fr_im[i], idx);
      end
   endtask

   initial begin
      rst        = 1'b1;
      data_valid = 1'b0;
      data_re    = '0;
      data_im    = '0;
      data_index = '0;
      #2;
      chk("init_mag_valid", MW'(mag_valid), '0);
      chk("init_peak_valid", MW'(peak_valid), '0);
      chk("init_peak_mag", peak_mag, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single sample 3-4j at bin 0.
      step(1'b1, 32'sd3, -32'sd4, 16'd0);
      idle(2);
      chk("single_mag", mag_out, MW'(25));
      chk("single_valid", MW'(mag_valid), MW'(1));
      idle(3);

      // Peak in lower half wins over larger bin above NFFT/2.
      clear_frame();
      fr_re[5]  = 32'sd100;
      fr_re[12] = 32'sd200;
      send_frame(1'b0);
      idle(5);
      chk("frameA_peak_mag", peak_mag, MW'(10000));
      chk("frameA_peak_idx", MW'(peak_index), MW'(5));

      // Tie keeps the lower bin; DC excluded.
      clear_frame();
      fr_re[0] = 32'sd1000;
      fr_re[3] = 32'sd7; fr_im[3] = 32'sd7;
      fr_re[6] = 32'sd7; fr_im[6] = 32'sd7;
      send_frame(1'b1);
      idle(5);
      chk("tie_peak_mag", peak_mag, MW'(98));
      chk("tie_peak_idx", MW'(peak_index), MW'(3));

      // All-zero frame.
      clear_frame();
      send_frame(1'b0);
      idle(5);
      chk("zero_peak_mag", peak_mag, '0);
      chk("zero_peak_idx", MW'(peak_index), '0);

      // Broken sequence 0,1,2,4 then a clean frame.
      step(1'b1, 32'sd50, 32'sd0, 16'd0);
      step(1'b1, 32'sd60, 32'sd0, 16'd1);
      step(1'b1, 32'sd70, 32'sd0, 16'd2);
      step(1'b1, 32'sd80, 32'sd0, 16'd4);
      idle(5);
      clear_frame();
      fr_re[7] = 32'sd5; fr_im[7] = -32'sd5;
      send_frame(1'b0);
      idle(5);
      chk("seq_peak_mag", peak_mag, MW'(50));
      chk("seq_peak_idx", MW'(peak_index), MW'(7));

      // Extreme operands.
      step(1'b1, 32'sh8000_0000, 32'sh8000_0000, 16'd3);
      idle(2);
      chk("extreme_mag", mag_out, 65'h0_8000_0000_0000_0000);
      idle(3);

      // Reset in the middle of a frame.
      for (int i = 0; i <= 8; i++) step(1'b1, 32'sd9, 32'sd9, 16'(i));
      do_reset();
      clear_frame();
      fr_re[2] = -32'sd11;
      send_frame(1'b0);
      idle(5);
      chk("post_rst_peak_mag", peak_mag, MW'(121));
      chk("post_rst_peak_idx", MW'(peak_index), MW'(2));

      // Randomized frames, some with injected discontinuities.
      for (int f = 0; f < 40; f++) begin
         random_frame($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
      end
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
